// File: rtl/dmem_mmio.sv
// dmem_mmio: data memory for the core MEM stage with a small register window.
//   - RAM: DEPTH_WORDS x 32-bit, asynchronous read, byte-lane writes, never reset.
//   - Registers at MMIO_BASE: TXDATA (push to TX FIFO), STATUS, MTIME, MTIMECMP.
//   - TX FIFO drained through a valid/ready byte stream.
//   - Free-running MTIME with a compare that raises a sticky pending flag.
// Ports:
//   clk, reset      single clock, synchronous active-low reset
//   addr, wdata     byte address and lane-aligned store data
//   byte_en         per-byte write enables
//   mem_write       store strobe
//   rdata           combinational read data for addr
//   tx_data/valid   FIFO head byte and non-empty flag
//   tx_ready        consumer accepts tx_data when high with tx_valid
//   timer_irq       timer pending flag
module dmem_mmio #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Address decode
  logic          ramSel, regSel;
  logic [1:0]    regOff;
  logic [AW-1:0] wordIdx;

  assign ramSel  = (addr[31:28] == 4'h0);
  assign regSel  = (addr[31:4] == MMIO_BASE[31:4]);
  assign regOff  = addr[3:2];
  assign wordIdx = addr[AW+1:2];   // upper address bits alias onto the array

  // Byte offset within a word never affects this block.
  logic unusedAddrBits;
  assign unusedAddrBits = ^addr[1:0];

  // Write strobes
  logic ramWe, regWe, pushReq, statWe, timeWe, cmpWe;

  assign ramWe   = mem_write & reset & ramSel;
  assign regWe   = mem_write & regSel;
  assign pushReq = regWe & (regOff == 2'd0) & byte_en[0];
  assign statWe  = regWe & (regOff == 2'd1) & byte_en[0];
  assign timeWe  = regWe & (regOff == 2'd2) & (&byte_en);
  assign cmpWe   = regWe & (regOff == 2'd3) & (&byte_en);

  // RAM
  logic [31:0] ram [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[wordIdx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // TX FIFO
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count;
  logic          full, pop, pushOk, pushRej;

  assign tx_valid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = tx_valid & tx_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pushOk   = pushReq & (~full | pop);
  assign pushRej  = pushReq & ~pushOk;
  assign tx_data  = fifoMem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk && reset) fifoMem[wrPtr] <= wdata[7:0];
  end

  // Control state
  logic        overflow, pending;
  logic [31:0] mtime, mtimecmp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      pending  <= 1'b0;
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (pop)    rdPtr <= rdPtr + 1'b1;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Set beats a same-cycle software clear for both sticky flags.
      if (pushRej)                 overflow <= 1'b1;
      else if (statWe && wdata[2]) overflow <= 1'b0;
      if (mtime == mtimecmp)       pending  <= 1'b1;
      else if (statWe && wdata[3]) pending  <= 1'b0;
      mtime <= timeWe ? wdata : mtime + 32'd1;
      if (cmpWe) mtimecmp <= wdata;
    end
  end

  assign timer_irq = pending;

  // Read path: reflects state before the current edge.
  logic [31:0] status;
  logic [3:0]  cnt4;

  assign cnt4   = 4'(count);
  assign status = {20'd0, cnt4, 4'd0, pending, overflow, full, ~tx_valid};

  always_comb begin
    rdata = '0;
    if (ramSel) begin
      rdata = ram[wordIdx];
    end else if (regSel) begin
      case (regOff)
        2'd0:    rdata = '0;
        2'd1:    rdata = status;
        2'd2:    rdata = mtime;
        default: rdata = mtimecmp;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;

  localparam logic [31:0] TXA = 32'h1000_0000;
  localparam logic [31:0] STA = 32'h1000_0004;
  localparam logic [31:0] MTA = 32'h1000_0008;
  localparam logic [31:0] CMA = 32'h1000_000C;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  byte_en = '0;
  logic        mem_write = 1'b0, tx_ready = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, timer_irq;

  int checks = 0, errors = 0;

  dmem_mmio dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .byte_en(byte_en),
    .mem_write(mem_write), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timer_irq(timer_irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_write = 1'b0;
    byte_en   = '0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic we);
    addr = a; wdata = d; byte_en = be; mem_write = we;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(a, d, be, 1'b1);
    tick();
    idle();
  endtask

  task automatic readChk(input string name, input logic [31:0] a, input logic [31:0] exp);
    idle();
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic doReset();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] ramM [16];
  logic [7:0]  q [$];
  logic        mOvf, mPend;
  logic [31:0] mTime, mCmp;

  function automatic logic [31:0] mRead(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:28] == 4'h0) r = ramM[a[5:2]];
    else if (a[31:4] == TXA[31:4]) begin
      case (a[3:2])
        2'd1: r = {20'd0, 4'(q.size()), 4'd0, mPend, mOvf, q.size() == 8, q.size() == 0};
        2'd2: r = mTime;
        2'd3: r = mCmp;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic modelStep();
    logic popNow, isReg, isRam, pushW, statW, acc, ovfSet;
    popNow = (q.size() > 0) && tx_ready;
    isReg  = (addr[31:4] == TXA[31:4]);
    isRam  = (addr[31:28] == 4'h0);
    pushW  = mem_write && isReg && addr[3:2] == 2'd0 && byte_en[0];
    statW  = mem_write && isReg && addr[3:2] == 2'd1 && byte_en[0];
    acc    = pushW && (q.size() < 8 || popNow);
    ovfSet = pushW && !acc;
    if (mTime == mCmp) mPend = 1'b1;
    else if (statW && wdata[3]) mPend = 1'b0;
    if (ovfSet) mOvf = 1'b1;
    else if (statW && wdata[2]) mOvf = 1'b0;
    if (popNow) void'(q.pop_front());
    if (acc) q.push_back(wdata[7:0]);
    if (mem_write && isReg && addr[3:2] == 2'd3 && byte_en == 4'hF) mCmp = wdata;
    if (mem_write && isReg && addr[3:2] == 2'd2 && byte_en == 4'hF) mTime = wdata;
    else mTime = mTime + 32'd1;
    if (mem_write && isRam)
      for (int i = 0; i < 4; i++)
        if (byte_en[i]) ramM[addr[5:2]][8*i +: 8] = wdata[8*i +: 8];
  endtask

  task automatic cyc();
    #1;
    chk("rnd_rdata", rdata, mRead(addr));
    chk("rnd_txv", tx_valid, q.size() > 0);
    if (q.size() > 0) chk("rnd_txd", tx_data, q[0]);
    chk("rnd_irq", timer_irq, mPend);
    modelStep();
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        we;
    logic        doChk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    tbl.push_back('{"ram_w0",       32'h0000_0040, 32'h1122_3344, 4'hF, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{"ram_rdw_old",  32'h0000_0040, 32'hAA00_0000, 4'h8, 1'b1, 1'b1, 32'h1122_3344});
    tbl.push_back('{"ram_lane",     32'h0000_0040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA22_3344});
    tbl.push_back('{"ram_alias",    32'h0000_1040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA22_3344});
    tbl.push_back('{"ram_alias_hi", 32'h0ABC_D040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA22_3344});
    tbl.push_back('{"unmap_w",      32'h2000_0040, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 32'h0});
    tbl.push_back('{"unmap_nohit",  32'h0000_0040, 32'h0,         4'h0, 1'b0, 1'b1, 32'hAA22_3344});
    tbl.push_back('{"above_win",    32'h1000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'h0});
    tbl.push_back('{"status_rst",   STA,           32'h0,         4'h0, 1'b0, 1'b1, 32'h1});
    tbl.push_back('{"txdata_rd",    TXA,           32'h0,         4'h0, 1'b0, 1'b1, 32'h0});
    tbl.push_back('{"cmp_rst",      CMA,           32'h0,         4'h0, 1'b0, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{"cmp_partial",  CMA,           32'h1234_5678, 4'h3, 1'b1, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{"cmp_ign",      CMA,           32'h0,         4'h0, 1'b0, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{"cmp_full_old", CMA,           32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'hFFFF_FFFF});
    tbl.push_back('{"cmp_full",     CMA,           32'h0,         4'h0, 1'b0, 1'b1, 32'h1234_5678});
    tbl.push_back('{"ram44_w",      32'h0000_0044, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{"ram44_lane1",  32'h0000_0044, 32'hFFFF_BBFF, 4'h2, 1'b1, 1'b0, 32'h0});
    tbl.push_back('{"ram44_rd",     32'h0000_0044, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0000_BB00});
  end

  initial begin
    #1;
    // Reset state
    doReset();
    chk("rst_txv", tx_valid, 1'b0);
    chk("rst_irq", timer_irq, 1'b0);
    readChk("rst_mtime", MTA, 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].we);
      #1;
      if (tbl[i].doChk) chk(tbl[i].name, rdata, tbl[i].exp);
      tick();
      idle();
    end

    // FIFO fill and overflow
    doReset();
    readChk("ram_after_rst", 32'h0000_0040, 32'hAA22_3344);
    tx_ready = 1'b0;
    for (int k = 1; k <= 9; k++) busWrite(TXA, 32'(k), 4'b0001);
    readChk("fill_status", STA, 32'h0000_0806);
    chk("fill_head", tx_data, 8'd1);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_v", tx_valid, 1'b1);
      chk("drain_d", tx_data, 8'(k));
      tick();
    end
    tx_ready = 1'b0;
    chk("drain_empty", tx_valid, 1'b0);
    readChk("ovf_sticky", STA, 32'h5);
    busWrite(STA, 32'h4, 4'b1110);
    readChk("ovf_noclr_be", STA, 32'h5);
    busWrite(STA, 32'h4, 4'b0001);
    readChk("ovf_clr", STA, 32'h1);

    // Full FIFO with simultaneous push and pop
    for (int k = 0; k < 8; k++) busWrite(TXA, 32'h10 + 32'(k), 4'b0001);
    readChk("full_status", STA, 32'h0000_0802);
    drive(TXA, 32'h5A, 4'b0001, 1'b1);
    tx_ready = 1'b1;
    #1;
    chk("pp_head", tx_data, 8'h10);
    tick();
    tx_ready = 1'b0;
    readChk("pp_status", STA, 32'h0000_0802);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("pp_drain", tx_data, (k == 8) ? 8'h5A : 8'h10 + 8'(k));
      tick();
    end
    tx_ready = 1'b0;
    readChk("pp_empty", STA, 32'h1);

    // Mid-operation reset
    doReset();
    busWrite(32'h0000_0080, 32'hCAFE_BABE, 4'hF);
    for (int k = 0; k < 9; k++) busWrite(TXA, 32'h21 + 32'(k), 4'b0001);
    tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    tx_ready = 1'b0;
    readChk("pre_rst_status", STA, 32'h0000_0304);
    busWrite(MTA, 32'd500, 4'hF);
    readChk("pre_rst_mtime", MTA, 32'd500);
    drive(TXA, 32'h77, 4'b0001, 1'b1);
    tx_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tx_ready = 1'b0;
    idle();
    chk("mid_rst_txv", tx_valid, 1'b0);
    readChk("mid_rst_status", STA, 32'h1);
    readChk("mid_rst_mtime", MTA, 32'h0);
    readChk("mid_rst_ram", 32'h0000_0080, 32'hCAFE_BABE);
    tick();
    readChk("mtime_resume", MTA, 32'h1);

    // Timer match
    doReset();
    busWrite(CMA, 32'd20, 4'hF);
    busWrite(MTA, 32'd10, 4'hF);
    for (int k = 0; k <= 10; k++) begin
      chk("irq_early", timer_irq, 1'b0);
      tick();
    end
    chk("irq_rise", timer_irq, 1'b1);
    readChk("irq_status", STA, 32'h9);
    busWrite(STA, 32'h8, 4'b0001);
    chk("irq_clr", timer_irq, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("irq_stay0", timer_irq, 1'b0);
    end
    // Set wins over a clear in the matching cycle
    busWrite(CMA, 32'd50, 4'hF);
    busWrite(MTA, 32'd48, 4'hF);
    tick();
    tick();
    busWrite(STA, 32'h8, 4'b0001);
    chk("irq_set_wins", timer_irq, 1'b1);
    busWrite(STA, 32'h8, 4'b0010);
    chk("irq_clr_be", timer_irq, 1'b1);
    busWrite(STA, 32'h8, 4'b0001);
    chk("irq_clr2", timer_irq, 1'b0);

    // Randomized run against the reference model
    doReset();
    tx_ready = 1'b0;
    q.delete();
    mOvf = 1'b0; mPend = 1'b0; mTime = 32'h0; mCmp = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      drive(32'(i) << 2, $urandom, 4'hF, 1'b1);
      cyc();
    end
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [31:0] a, d;
      r = $urandom_range(0, 9);
      d = $urandom;
      case (r)
        0, 1, 2, 9: a = {4'h0, 16'($urandom), 6'd0, 4'($urandom), 2'($urandom)};
        3, 4:       a = TXA | 32'($urandom_range(0, 3));
        5:          a = STA;
        6:          begin a = MTA; d = 32'($urandom_range(0, 40)); end
        7:          begin a = CMA; d = 32'($urandom_range(0, 40)); end
        default:    a = ($urandom_range(0, 1) != 0) ? (32'h2000_0000 | ($urandom & 32'h0FFF_FFFF))
                                                   : (32'h1000_0010 | ($urandom & 32'h0000_0FEF));
      endcase
      drive(a, d, ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom),
            (r != 9) && ($urandom_range(0, 3) != 0));
      tx_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit RAM words; SHALL be a power of two.
REQ-002 Parameter FIFO_DEPTH, default 8: number of TX FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter MMIO_BASE, default 32'h1000_0000: base address of the register window.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 addr  input  32  byte address from the core MEM stage.
REQ-007 wdata  input  32  store data, already lane-aligned by the core.
REQ-008 byte_en  input  4  per-byte write enables.
REQ-009 mem_write  input  1  store strobe; writes occur only when it is 1.
REQ-010 rdata  output  32  combinational read data for addr, valid in the same cycle.
REQ-011 tx_data  output  8  FIFO head byte.
REQ-012 tx_valid  output  1  FIFO non-empty.
REQ-013 tx_ready  input  1  consumer accepts tx_data when it is high together with tx_valid.
REQ-014 timer_irq  output  1  timer pending flag.

Function
REQ-015 Decode: addr[31:28]==0 selects RAM; addr[31:4]==MMIO_BASE[31:4] selects registers; all other addresses read 0 and ignore writes.
REQ-016 RAM: word index = addr[log2(DEPTH_WORDS)+1:2], so higher bits wrap; asynchronous read of the full word; each lane i is written on the clock edge when mem_write and byte_en[i] are both 1.
REQ-017 RAM contents SHALL NOT be reset.
REQ-018 Register map, word offset addr[3:2]:
- 0 TXDATA: reads 0; a write with byte_en[0]=1 pushes wdata[7:0].
- 1 STATUS: bit0 empty, bit1 full, bit2 overflow, bit3 pending, bits[11:8] count (zero-extended), all other bits 0. A write clears overflow when wdata[2]=1 and clears pending when wdata[3]=1; byte_en[0] must be 1.
- 2 MTIME: read/write. A write applies only when byte_en=4'b1111; partial writes are ignored.
- 3 MTIMECMP: read/write, with the same full-word write rule as MTIME.
REQ-019 FIFO:
- A pop occurs when tx_valid and tx_ready are both 1.
- A push is accepted when count<FIFO_DEPTH, or when full and a pop occurs in the same cycle.
- A rejected push sets overflow (sticky) and leaves contents unchanged.
- Simultaneous push and pop leaves count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
REQ-020 tx_data SHALL equal the oldest entry whenever tx_valid=1; it is held stable while tx_valid=1 and tx_ready=0.
REQ-021 MTIME:
- Increments by 1 every cycle, wrapping from 32'hFFFF_FFFF to 0.
- A software write in the same cycle overrides the increment; the next value is wdata.
REQ-022 Pending:
- Set on the edge following any cycle in which MTIME==MTIMECMP (current values).
- Set has priority over a same-cycle clear.
- timer_irq = pending.
REQ-023 Read data reflects register state before the current edge; read-during-write returns the old value.
REQ-024 Overflow set and clear in the same cycle: set wins.

Reset
REQ-025 When reset=0 at an edge, the block SHALL reset its state as follows:
- FIFO empty: pointers and count 0, tx_valid=0.
- overflow=0, pending=0, timer_irq=0.
- MTIME=0, MTIMECMP=32'hFFFF_FFFF.
REQ-026 Reset SHALL take priority over every same-cycle push, pop and write; a pop in progress is discarded.
REQ-027 Operation resumes on the first edge with reset=1, with MTIME counting from 0.

Verification
REQ-028 RAM byte-lane write:
- Store 32'h11223344 to 0x40, then store wdata=32'hAA00_0000 with byte_en=4'b1000.
- Reading 0x40 returns 32'hAA223344.
- Reading 0x40+4*DEPTH_WORDS aliases and returns the same word.
REQ-029 FIFO fill and overflow:
- With tx_ready=0, push bytes 1..9 to TXDATA.
- Required: STATUS=32'h0000_0806 (count 8, full, overflow), tx_data=1.
- Then tx_ready=1 for 8 cycles: bytes 1..8 appear in order, tx_valid=0 afterwards.
REQ-030 Full FIFO with simultaneous push and pop:
- Push 8'h5A while full with tx_ready=1.
- Count stays 8, overflow stays 0, and 8'h5A emerges last.
REQ-031 Timer match:
- Write MTIMECMP=20 and MTIME=10.
- timer_irq rises exactly 11 cycles after the MTIME write edge.
- A STATUS write of 32'h8 clears it; with MTIME past MTIMECMP it stays 0 until wrap.
REQ-032 Mid-operation reset:
- With 3 bytes queued, overflow=1 and MTIME=500, hold reset=0 for one edge.
- Required: tx_valid=0, STATUS=32'h1, MTIME reads 0 in the reset-release cycle, and a previously written RAM word is unchanged.
